// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : multi-cycle unsigned shift-add multiplier / restoring divider
// Optional divider enabled by defining MULDIV_DIV_EN.  Revision 1.0
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zf,
   output logic             cf,
   output logic             div_by_zero
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [2*WIDTH-1:0] acc, acc_nx, mul_nx;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH:0] pre;
   logic             accept, last, div_sel, dz_start;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             res_zf, res_cf;

`ifdef MULDIV_DIV_EN
   logic             op_r, dbz_r, ge;
   logic [WIDTH-1:0] rem_r, rem_nx;
   logic [WIDTH:0]   sh, diff;
   assign div_sel     = op;
   assign dz_start    = accept & op & (b == '0);
   assign div_by_zero = dbz_r;
`else
   logic unused_op;
   assign unused_op   = op;
   assign div_sel     = 1'b0;
   assign dz_start    = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   assign accept = start & ((state == S_IDLE) | (state == S_DONE));
   assign last   = (cnt == CW'(WIDTH - 1));
   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nx = dz_start ? S_DONE : S_RUN;
            else        state_nx = S_IDLE;
         end
         S_RUN:   if (last) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   // One iteration step; acc holds {H,L} for MUL and {unused,Q} for DIV.
   always_comb begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
      pre    = acc[0] ? {sum, acc[WIDTH-1:0]} : {1'b0, acc};
      mul_nx = pre[2*WIDTH:1];
      acc_nx = mul_nx;
      res_hi = mul_nx[2*WIDTH-1:WIDTH];
      res_lo = mul_nx[WIDTH-1:0];
      res_zf = (mul_nx == '0);
      res_cf = (mul_nx[2*WIDTH-1:WIDTH] != '0);
`ifdef MULDIV_DIV_EN
      sh     = {rem_r, acc[WIDTH-1]};
      diff   = sh - {1'b0, m_r};
      ge     = ~diff[WIDTH];
      rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      if (op_r) begin
         acc_nx = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
         res_hi = rem_nx;
         res_lo = acc_nx[WIDTH-1:0];
         res_zf = (acc_nx[WIDTH-1:0] == '0);
         res_cf = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
         m_r <= '0;
         hi  <= '0;
         lo  <= '0;
         zf  <= 1'b0;
         cf  <= 1'b0;
`ifdef MULDIV_DIV_EN
         op_r  <= 1'b0;
         dbz_r <= 1'b0;
         rem_r <= '0;
`endif
      end else if (accept) begin
         cnt <= '0;
         m_r <= div_sel ? b : a;
         acc <= {{WIDTH{1'b0}}, (div_sel ? a : b)};
`ifdef MULDIV_DIV_EN
         op_r  <= op;
         rem_r <= '0;
         if (dz_start) begin
            hi    <= a;
            lo    <= '1;
            zf    <= 1'b0;
            cf    <= 1'b0;
            dbz_r <= 1'b1;
         end
`endif
      end else if (state == S_RUN) begin
         cnt <= cnt + 1'b1;
         acc <= acc_nx;
`ifdef MULDIV_DIV_EN
         rem_r <= rem_nx;
         if (last) dbz_r <= 1'b0;
`endif
         if (last) begin
            hi <= res_hi;
            lo <= res_lo;
            zf <= res_zf;
            cf <= res_cf;
         end
      end
   end
endmodule
`default_nettype wire
